output_arbiter: RTL

Shares the single output handler between up to `NUM_REQ` response sources, such as the command responder and the interrupt/status reporter. Each source presents a 256-bit payload buffer, a status byte and a byte count. The arbiter grants one source at a time in round-robin order and latches that source's payload into the handler. It then pulses the handler's begin strobe, waits for the handler's finished signal and acknowledges the source. The arbiter sits between the response sources and the output handler, which in turn drives the UART.

---
 rtl/output_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/output_arbiter.sv
// Round-robin arbiter that hands the single output handler to one response source at a time.
// Optional WAIT watchdog is built only when OUTPUT_ARB_TIMEOUT_EN is defined.
module output_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ*256-1:0] req_buffer_i,
  input  logic [NUM_REQ*8-1:0]   req_status_i,
  input  logic [NUM_REQ*16-1:0]  req_count_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic [NUM_REQ-1:0]     ack_o,
  output logic                   busy_o,
  output logic                   timeout_o,
  output logic [255:0]           oh_buffer_o,
  output logic [7:0]             oh_status_o,
  output logic [15:0]            oh_count_o,
  output logic                   oh_begin_o,
  input  logic                   oh_finished_i
);

  localparam int LG = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  if (NUM_REQ < 1 || NUM_REQ > 4 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_err
    $error("output_arbiter: parameter out of range");
  end

  logic [255:0] src_buf [NUM_REQ];
  logic [7:0]   src_st  [NUM_REQ];
  logic [15:0]  src_cnt [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_src
    assign src_buf[i] = req_buffer_i[i*256 +: 256];
    assign src_st[i]  = req_status_i[i*8 +: 8];
    assign src_cnt[i] = req_count_i[i*16 +: 16];
  end

  logic [2:0]         state_q, state_d;
  logic [LG-1:0]      sel_q, sel_d, last_q, last_d, win_idx;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [255:0]       oh_buffer_q, oh_buffer_d;
  logic [7:0]         oh_status_q, oh_status_d;
  logic [15:0]        oh_count_q, oh_count_d;
  logic               wait_expired;

  // Scan offsets high-to-low so the nearest requester above last_q wins.
  always_comb begin
    win_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_i[(int'(last_q) + k) % NUM_REQ]) win_idx = LG'((int'(last_q) + k) % NUM_REQ);
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    grant_d     = grant_q;
    oh_buffer_d = oh_buffer_q;
    oh_status_d = oh_status_q;
    oh_count_d  = oh_count_q;
    case (state_q)
      IDLE: if (|req_i) begin
        state_d = LOAD;
        sel_d   = win_idx;
        grant_d = NUM_REQ'(1) << win_idx;
      end
      LOAD: begin
        oh_buffer_d = src_buf[sel_q];
        oh_status_d = src_st[sel_q];
        // Payload holds 32 bytes at most.
        oh_count_d  = (src_cnt[sel_q] > 16'd32) ? 16'd32 : src_cnt[sel_q];
        state_d     = (src_cnt[sel_q] == 16'd0) ? DONE : START;
      end
      START: state_d = WAIT;
      WAIT:  if (oh_finished_i || wait_expired) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        last_d  = sel_q;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      last_q      <= LG'(NUM_REQ - 1);
      grant_q     <= '0;
      oh_buffer_q <= '0;
      oh_status_q <= '0;
      oh_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      oh_buffer_q <= oh_buffer_d;
      oh_status_q <= oh_status_d;
      oh_count_q  <= oh_count_d;
    end
  end

`ifdef OUTPUT_ARB_TIMEOUT_EN
  logic [15:0] wcnt_q;
  logic        to_q;

  assign wait_expired = (state_q == WAIT) && !oh_finished_i && (wcnt_q == 16'(TIMEOUT - 1));

  // Counter restarts in START so it reads 0 on the first WAIT cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wcnt_q <= '0;
      to_q   <= 1'b0;
    end else begin
      if (state_q == START)     wcnt_q <= '0;
      else if (state_q == WAIT) wcnt_q <= wcnt_q + 16'd1;
      to_q <= wait_expired;
    end
  end

  assign timeout_o = to_q && (state_q == DONE);
`else
  assign wait_expired = 1'b0;
  assign timeout_o    = 1'b0;
`endif

  assign grant_o     = grant_q;
  assign ack_o       = (state_q == DONE) ? grant_q : '0;
  assign busy_o      = (state_q != IDLE);
  assign oh_begin_o  = (state_q == START);
  assign oh_buffer_o = oh_buffer_q;
  assign oh_status_o = oh_status_q;
  assign oh_count_o  = oh_count_q;

endmodule
